fix_msg_loader: RTL

Host-to-engine counterpart of the console capture path. A Nios II master writes a FIX message byte-by-byte into an internal buffer through an Avalon-MM slave port, then issues a send command. The block streams the buffered bytes into the end-to-end engine's message input with a valid/ready handshake and a last-byte marker. Status and byte count are readable over the same slave port.

---
 rtl/fix_msg_loader.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fix_msg_loader.sv
// FIX message loader: an Avalon-MM slave fills a byte buffer, and a START
// command streams the buffered bytes to the engine over valid/ready with a last marker.
module fix_msg_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            slave_address,
    input  logic                  slave_read,
    output logic [7:0]            slave_readdata,
    input  logic                  slave_write,
    input  logic [7:0]            slave_writedata,
    output logic [DATA_WIDTH-1:0] msg_data,
    output logic                  msg_valid,
    output logic                  msg_last,
    input  logic                  msg_ready,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_CNT_LO = 3'd3;
    localparam logic [2:0] A_CNT_HI = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO   = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = {(ADDR_WIDTH + 1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   msg_data_q, msg_data_d;
    logic                    msg_valid_q, msg_valid_d;
    logic                    msg_last_q, msg_last_d;
    logic [7:0]              rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_rdata_q;
    logic [ADDR_WIDTH-1:0]   ram_raddr_s;
    logic                    ram_we_s;
    logic                    done_set_s;
    logic                    clear_s;
    logic                    status_rd_s;
    logic [ADDR_WIDTH-1:0]   next_ptr_s;
    logic [ADDR_WIDTH:0]     last_idx_s;
    logic [15:0]             count_ext_s;

    assign clear_s     = slave_write && (slave_address == A_CTRL) && slave_writedata[1];
    assign status_rd_s = slave_read && (slave_address == A_STATUS);
    assign next_ptr_s  = rd_ptr_q + PTR_ONE;
    assign last_idx_s  = count_q - CNT_ONE;
    assign count_ext_s = 16'(count_q);

    // Next-state logic for the command decoder, streaming FSM and read mux.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        busy_d      = busy_q;
        msg_data_d  = msg_data_q;
        msg_valid_d = msg_valid_q;
        msg_last_d  = msg_last_q;
        rdata_d     = rdata_q;
        ram_we_s    = 1'b0;
        ram_raddr_s = next_ptr_s;
        done_set_s  = 1'b0;

        if (clear_s) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = PTR_ZERO;
            rd_ptr_d    = PTR_ZERO;
            count_d     = CNT_ZERO;
            done_d      = 1'b0;
            ovf_d       = 1'b0;
            err_d       = 1'b0;
            busy_d      = 1'b0;
            msg_valid_d = 1'b0;
            msg_last_d  = 1'b0;
        end else begin
            // The output register doubles as the hold stage; ram_rdata_q always
            // carries the beat after it, re-read while the engine stalls.
            case (state_q)
                ST_IDLE: begin
                    ram_raddr_s = PTR_ZERO;
                end
                ST_FETCH: begin
                    msg_data_d  = ram_rdata_q;
                    msg_valid_d = 1'b1;
                    msg_last_d  = (count_q == CNT_ONE);
                    state_d     = ST_STREAM;
                end
                ST_STREAM: begin
                    if (msg_ready) begin
                        rd_ptr_d = next_ptr_s;
                        if (msg_last_q) begin
                            done_set_s  = 1'b1;
                            busy_d      = 1'b0;
                            msg_valid_d = 1'b0;
                            msg_last_d  = 1'b0;
                            state_d     = ST_IDLE;
                        end else begin
                            msg_data_d  = ram_rdata_q;
                            msg_last_d  = ({1'b0, next_ptr_s} == last_idx_s);
                            ram_raddr_s = next_ptr_s + PTR_ONE;
                        end
                    end else begin
                        ram_raddr_s = next_ptr_s;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    msg_valid_d = 1'b0;
                    msg_last_d  = 1'b0;
                end
            endcase

            if (slave_write) begin
                case (slave_address)
                    A_DATA: begin
                        if (busy_q) begin
                            err_d = 1'b1;
                        end else if (count_q == FULL_COUNT) begin
                            ovf_d = 1'b1;
                        end else begin
                            ram_we_s = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            count_d  = count_q + CNT_ONE;
                        end
                    end
                    A_CTRL: begin
                        if (slave_writedata[0]) begin
                            if (busy_q) begin
                                err_d = 1'b1;
                            end else if (count_q == CNT_ZERO) begin
                                done_set_s = 1'b1;
                            end else begin
                                state_d  = ST_FETCH;
                                busy_d   = 1'b1;
                                rd_ptr_d = PTR_ZERO;
                            end
                        end else begin
                            err_d = err_q;
                        end
                    end
                    default: begin
                        ram_we_s = 1'b0;
                    end
                endcase
            end else begin
                ram_we_s = 1'b0;
            end

            // A done event wins over a same-cycle STATUS read-to-clear.
            if (done_set_s) begin
                done_d = 1'b1;
            end else if (status_rd_s) begin
                done_d = 1'b0;
            end else begin
                done_d = done_q;
            end
        end

        if (slave_read) begin
            case (slave_address)
                A_STATUS: rdata_d = {4'b0000, (count_q == CNT_ZERO), err_q, ovf_q,
                                     (done_q | done_set_s)};
                A_CNT_LO: rdata_d = count_ext_s[7:0];
                A_CNT_HI: rdata_d = count_ext_s[15:8];
                default:  rdata_d = 8'h00;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            msg_data_q  <= {DATA_WIDTH{1'b0}};
            msg_valid_q <= 1'b0;
            msg_last_q  <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            msg_data_q  <= msg_data_d;
            msg_valid_q <= msg_valid_d;
            msg_last_q  <= msg_last_d;
            rdata_q     <= rdata_d;
        end
    end

    // Message buffer: synchronous write, registered read.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[wr_ptr_q] <= DATA_WIDTH'(slave_writedata);
        end
        ram_rdata_q <= mem[ram_raddr_s];
    end

    assign slave_readdata = rdata_q;
    assign msg_data       = msg_data_q;
    assign msg_valid      = msg_valid_q;
    assign msg_last       = msg_last_q;
    assign busy           = busy_q;

endmodule
